mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: CHECK_ALIGN, default 1; when 1, word accesses with addr[1:0]!=0 are suppressed and flagged.
REQ-002 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ex_to_mem  input  ex_to_mem_s  registered execute-stage bundle: alu_result, write_data, mem_write, reg_write, rd, mem_read.
REQ-005 dmem_req_valid  output  1  data-memory request valid.
REQ-006 dmem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 dmem_we  output  1  1 = store, 0 = load.
REQ-008 dmem_addr  output  32  byte address, equal to ex_to_mem.alu_result.
REQ-009 dmem_wdata  output  32  store data, equal to ex_to_mem.write_data.
REQ-010 dmem_rsp_valid  input  1  load data valid.
REQ-011 dmem_rdata  input  32  load data.
REQ-012 mem_to_wb  output  mem_to_wb_s  registered bundle to writeback: result[31:0], rd[4:0], reg_write.
REQ-013 bp_mem  output  32  bypass value to execute, combinationally equal to ex_to_mem.alu_result.
REQ-014 stall_mem  output  1  combinational; while high, upstream stages hold ex_to_mem stable.
REQ-015 misalign_err  output  1  registered one-cycle pulse on a suppressed misaligned access.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT_RSP.
REQ-017 mem_op = mem_read | mem_write; when both are set, the access SHALL be a store.
REQ-018 IDLE with no mem_op: no request; next cycle mem_to_wb = {alu_result, rd, reg_write}; stall_mem=0.
REQ-019 IDLE with aligned mem_op: dmem_req_valid=1 in the same cycle.
REQ-020 IDLE, store, ready=1: store completes; stall_mem=0; next cycle mem_to_wb.reg_write=0; state stays IDLE.
REQ-021 IDLE, load, ready=1: go to WAIT_RSP; stall_mem=1.
REQ-022 IDLE, mem_op, ready=0: go to REQ; stall_mem=1.
REQ-023 REQ: dmem_req_valid held at 1 with addr, we and wdata stable; stall_mem=1 until ready.
REQ-024 REQ, ready=1: a store returns to IDLE with stall_mem=0 that cycle; a load goes to WAIT_RSP.
REQ-025 WAIT_RSP: dmem_req_valid=0; stall_mem=1 until dmem_rsp_valid.
REQ-026 WAIT_RSP, rsp_valid=1: stall_mem=0 that cycle; next cycle mem_to_wb = {dmem_rdata, rd, reg_write}; state -> IDLE.
REQ-027 dmem_rsp_valid outside WAIT_RSP SHALL be ignored; minimum load latency is accept + 1 cycle.
REQ-028 While stall_mem=1, each cycle mem_to_wb.reg_write SHALL be written 0 (bubble).
REQ-029 Misaligned with CHECK_ALIGN=1: no request; misaligned load or store writes a bubble; misalign_err=1 next cycle.
REQ-030 bp_mem SHALL NOT present load data; load-use hazards belong to the hazard unit.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, mem_to_wb to all zeros, and misalign_err=0.
REQ-032 During reset, dmem_req_valid and stall_mem SHALL be 0.
REQ-033 Reset in REQ or WAIT_RSP abandons the access; a late dmem_rsp_valid after reset is ignored.

Structure
REQ-034 mem_to_wb_s and mem_state_e SHALL be added to riscv_structures.sv next to ex_to_mem_s.
REQ-035 Single module; no sub-module; the FSM and output register live in mem_stage.

Verification
REQ-036 ALU op: alu_result=0x0000_0010, rd=5, reg_write=1 -> next cycle mem_to_wb={0x10, 5, 1}, no dmem request.
REQ-037 Store, addr 0x100, data 0xDEADBEEF, ready=1 -> single-cycle request with we=1, stall_mem=0, bubble to WB.
REQ-038 Load, addr 0x200, ready=0 for 2 cycles, rsp 3 cycles after accept with data 0xCAFEF00D, rd=7 -> stall_mem high throughout, valid stable; mem_to_wb={0xCAFEF00D, 7, 1}.
REQ-039 Load, addr 0x203, CHECK_ALIGN=1 -> no request; misalign_err pulse; reg_write=0.
REQ-040 rst_n dropped in WAIT_RSP, rsp_valid asserted 1 cycle after release -> state IDLE, mem_to_wb unchanged at zero.

Source files
------------

// File: rtl/riscv_structures.sv
// Shared pipeline bundles and the memory-stage state encoding.
package riscv_structures;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mem_read;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_to_wb_s;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory requests and registers the writeback bundle.
// Latency: ALU results and stores 1 cycle; loads accept + response + 1 cycle.
// Backpressure: stall_mem holds upstream while waiting on dmem_req_ready or dmem_rsp_valid.
module mem_stage
    import riscv_structures::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ex_to_mem_s  ex_to_mem,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [31:0] bp_mem,
    output logic        stall_mem,
    output logic        misalign_err
);

    mem_state_e state;

    logic mem_op;
    logic is_store;
    logic misaligned;
    logic go;

    assign mem_op     = ex_to_mem.mem_read | ex_to_mem.mem_write;
    assign is_store   = ex_to_mem.mem_write;
    assign misaligned = CHECK_ALIGN && mem_op && (ex_to_mem.alu_result[1:0] != 2'b00);
    assign go         = mem_op && !misaligned;

    assign dmem_we    = is_store;
    assign dmem_addr  = ex_to_mem.alu_result;
    assign dmem_wdata = ex_to_mem.write_data;
    // Load data never reaches the bypass; the hazard unit stalls load-use instead.
    assign bp_mem     = ex_to_mem.alu_result;

    always_comb begin
        dmem_req_valid = 1'b0;
        stall_mem      = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    dmem_req_valid = go;
                    stall_mem      = go && !(is_store && dmem_req_ready);
                end
                REQ: begin
                    dmem_req_valid = 1'b1;
                    stall_mem      = !(is_store && dmem_req_ready);
                end
                WAIT_RSP: begin
                    stall_mem = !dmem_rsp_valid;
                end
                default: begin
                    dmem_req_valid = 1'b0;
                    stall_mem      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_to_wb    <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) && misaligned;
            // Default is a bubble; only a completed ALU op or load writes back.
            mem_to_wb    <= '0;
            unique case (state)
                IDLE: begin
                    if (!mem_op) begin
                        mem_to_wb <= '{result: ex_to_mem.alu_result, rd: ex_to_mem.rd,
                                       reg_write: ex_to_mem.reg_write};
                    end else if (go) begin
                        if (!dmem_req_ready)
                            state <= REQ;
                        else if (!is_store)
                            state <= WAIT_RSP;
                    end
                end
                REQ: begin
                    if (dmem_req_ready)
                        state <= is_store ? IDLE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state     <= IDLE;
                        mem_to_wb <= '{result: dmem_rdata, rd: ex_to_mem.rd,
                                       reg_write: ex_to_mem.reg_write};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, stalled loads, misalignment, reset.
module tb_mem_stage;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_to_mem_s  ex_to_mem;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    mem_to_wb_s  mem_to_wb;
    logic [31:0] bp_mem;
    logic        stall_mem;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_to_mem(ex_to_mem),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .mem_to_wb(mem_to_wb), .bp_mem(bp_mem), .stall_mem(stall_mem),
        .misalign_err(misalign_err)
    );

    // Move to 1 time unit after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic mw,
                          input logic rw, input logic [4:0] rd, input logic mr);
        ex_to_mem.alu_result = alu;
        ex_to_mem.write_data = wd;
        ex_to_mem.mem_write  = mw;
        ex_to_mem.reg_write  = rw;
        ex_to_mem.rd         = rd;
        ex_to_mem.mem_read   = mr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rdata = '0;
        set_ex(32'h0000_0040, 32'h0, 1'b0, 1'b1, 5'd2, 1'b1);
        #3;
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", dmem_req_valid); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_mem); end
        total++; if (mem_to_wb !== 38'h0) begin bad++; $display("FAIL rst_wb got=%h exp=0", mem_to_wb); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
        tick();
        set_ex(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        tick();
        set_ex(32'h0000_0010, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #2;
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL alu_no_req got=%b exp=0", dmem_req_valid); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall_mem); end
        total++; if (bp_mem !== 32'h10) begin bad++; $display("FAIL alu_bp got=%h exp=10", bp_mem); end
        tick();
        dmem_rsp_valid = 1'b0;
        total++; if (mem_to_wb !== {32'h10, 5'd5, 1'b1}) begin bad++; $display("FAIL alu_wb got=%h exp=%h", mem_to_wb, {32'h10, 5'd5, 1'b1}); end
    endtask

    task automatic test_store();
        set_ex(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 1'b0);
        dmem_req_ready = 1'b1;
        #2;
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b exp=1", dmem_req_valid); end
        total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL st_we got=%b exp=1", dmem_we); end
        total++; if (dmem_addr !== 32'h100) begin bad++; $display("FAIL st_addr got=%h exp=100", dmem_addr); end
        total++; if (dmem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", dmem_wdata); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL st_stall got=%b exp=0", stall_mem); end
        tick();
        total++; if (mem_to_wb.reg_write !== 1'b0) begin bad++; $display("FAIL st_bubble got=%b exp=0", mem_to_wb.reg_write); end
        // An ALU op right behind the store proves the FSM stayed in IDLE.
        set_ex(32'h0000_0055, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
        tick();
        total++; if (mem_to_wb !== {32'h55, 5'd1, 1'b1}) begin bad++; $display("FAIL st_idle_wb got=%h exp=%h", mem_to_wb, {32'h55, 5'd1, 1'b1}); end
    endtask

    task automatic test_store_backpressure();
        set_ex(32'h0000_0104, 32'h1234_5678, 1'b1, 1'b0, 5'd0, 1'b0);
        dmem_req_ready = 1'b0;
        #2;
        total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL stbp_stall0 got=%b exp=1", stall_mem); end
        tick();
        dmem_req_ready = 1'b1;
        #2;
        total++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1) begin bad++; $display("FAIL stbp_req got=%b%b exp=11", dmem_req_valid, dmem_we); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL stbp_release got=%b exp=0", stall_mem); end
        tick();
        set_ex(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        total++; if (dmem_req_valid !== 1'b0 || stall_mem !== 1'b0) begin bad++; $display("FAIL stbp_idle got=%b%b exp=00", dmem_req_valid, stall_mem); end
    endtask

    task automatic test_load_wait();
        set_ex(32'h0000_0200, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1);
        dmem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) dmem_req_ready = 1'b1;
            #2;
            total++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h200 || dmem_we !== 1'b0) begin
                bad++; $display("FAIL ld_req_c%0d got=%b/%h/%b exp=1/200/0", c, dmem_req_valid, dmem_addr, dmem_we); end
            total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL ld_stall_req_c%0d got=%b exp=1", c, stall_mem); end
            tick();
            total++; if (mem_to_wb.reg_write !== 1'b0) begin bad++; $display("FAIL ld_bubble_c%0d got=%b exp=0", c, mem_to_wb.reg_write); end
        end
        dmem_req_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            total++; if (dmem_req_valid !== 1'b0 || stall_mem !== 1'b1) begin
                bad++; $display("FAIL ld_wait_c%0d got=%b%b exp=01", c, dmem_req_valid, stall_mem); end
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #2;
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL ld_rsp_stall got=%b exp=0", stall_mem); end
        tick();
        dmem_rsp_valid = 1'b0;
        set_ex(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        total++; if (mem_to_wb !== {32'hCAFE_F00D, 5'd7, 1'b1}) begin bad++; $display("FAIL ld_wb got=%h exp=%h", mem_to_wb, {32'hCAFE_F00D, 5'd7, 1'b1}); end
    endtask

    task automatic test_misalign();
        set_ex(32'h0000_0203, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1);
        dmem_req_ready = 1'b1;
        #2;
        total++; if (dmem_req_valid !== 1'b0 || stall_mem !== 1'b0) begin bad++; $display("FAIL mis_req got=%b%b exp=00", dmem_req_valid, stall_mem); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_early got=%b exp=0", misalign_err); end
        tick();
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
        total++; if (mem_to_wb.reg_write !== 1'b0) begin bad++; $display("FAIL mis_bubble got=%b exp=0", mem_to_wb.reg_write); end
        set_ex(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
    endtask

    task automatic test_reset_wait();
        set_ex(32'h0000_0300, 32'h0, 1'b0, 1'b1, 5'd9, 1'b1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        #1;
        total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL rw_in_wait got=%b exp=1", stall_mem); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_to_wb !== 38'h0 || stall_mem !== 1'b0 || dmem_req_valid !== 1'b0) begin
            bad++; $display("FAIL rw_async got=%h/%b/%b exp=0/0/0", mem_to_wb, stall_mem, dmem_req_valid); end
        set_ex(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        #2;
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL rw_late_stall got=%b exp=0", stall_mem); end
        tick();
        dmem_rsp_valid = 1'b0;
        total++; if (mem_to_wb !== 38'h0) begin bad++; $display("FAIL rw_late_wb got=%h exp=0", mem_to_wb); end
        // A fresh ALU op confirms the FSM came back in IDLE.
        set_ex(32'h0000_0077, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0);
        tick();
        total++; if (mem_to_wb !== {32'h77, 5'd4, 1'b1}) begin bad++; $display("FAIL rw_idle_wb got=%h exp=%h", mem_to_wb, {32'h77, 5'd4, 1'b1}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_store_backpressure();
        test_load_wait();
        test_misalign();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
